// File: rtl/traffic_pattern_gen.sv
// Serialises a programmable vehicle pattern (Bike=0, Car=1) MSB first over a valid/ready stream.
// Optional `TRAFFIC_PATTERN_GEN_NOISE_EN fills inter-pattern gaps with LFSR filler traffic.
module traffic_pattern_gen #(
  parameter int unsigned PAT_W = 5,
  parameter int unsigned REP_W = 8,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             ready_in,
  output logic             d_out,
  output logic             valid_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] pattern_q;
  logic [REP_W-1:0] rep_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [IDX_W-1:0] idx;

  logic             xfer;
  logic             last_bit;
  logic             last_rep;
  logic [IDX_W-1:0] idx_nxt;
  logic             bit_nxt;
  logic             msb_q;

  assign xfer     = valid_out & ready_in;
  assign last_bit = (idx == LAST_IDX);
  assign last_rep = (rep_q == REP_W'(1));
  assign idx_nxt  = idx + IDX_W'(1);
  // Only consumed when idx is not the last bit, so idx_nxt never runs past the pattern.
  assign bit_nxt  = pattern_q[LAST_IDX - idx_nxt];
  assign msb_q    = pattern_q[PAT_W-1];

`ifdef TRAFFIC_PATTERN_GEN_NOISE_EN
  logic [7:0] lfsr;
  logic [7:0] lfsr_nxt;
  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pattern_q <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      idx       <= '0;
      d_out     <= 1'b0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef TRAFFIC_PATTERN_GEN_NOISE_EN
      lfsr      <= 8'hA5;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          d_out     <= 1'b0;
          valid_out <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          if (start) begin
            pattern_q <= pattern;
            rep_q     <= (repeat_cnt == '0) ? REP_W'(1) : repeat_cnt;
            gap_q     <= gap;
            idx       <= '0;
            state     <= S_SEND;
            valid_out <= 1'b1;
            d_out     <= pattern[PAT_W-1];
            busy      <= 1'b1;
          end
        end

        S_SEND: begin
          if (xfer) begin
            if (last_bit) begin
              idx   <= '0;
              rep_q <= rep_q - REP_W'(1);
              if (last_rep) begin
                state     <= S_DONE;
                valid_out <= 1'b0;
                d_out     <= 1'b0;
                done      <= 1'b1;
              end else if (gap_q == '0) begin
                d_out <= msb_q;
              end else begin
                gap_cnt <= gap_q;
                state   <= S_GAP;
`ifdef TRAFFIC_PATTERN_GEN_NOISE_EN
                valid_out <= 1'b1;
                d_out     <= lfsr[0];
`else
                valid_out <= 1'b0;
                d_out     <= 1'b0;
`endif
              end
            end else begin
              idx   <= idx_nxt;
              d_out <= bit_nxt;
            end
          end
        end

        S_GAP: begin
`ifdef TRAFFIC_PATTERN_GEN_NOISE_EN
          // Filler bits obey the handshake: count and LFSR move only on accepted bits.
          if (xfer) begin
            lfsr    <= lfsr_nxt;
            gap_cnt <= gap_cnt - GAP_W'(1);
            if (gap_cnt == GAP_W'(1)) begin
              state <= S_SEND;
              d_out <= msb_q;
            end else begin
              d_out <= lfsr_nxt[0];
            end
          end
`else
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) begin
            state     <= S_SEND;
            valid_out <= 1'b1;
            d_out     <= msb_q;
          end
`endif
        end

        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          valid_out <= 1'b0;
          d_out     <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          valid_out <= 1'b0;
          d_out     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_pattern_gen.sv
// Directed bench for traffic_pattern_gen: table of transfers plus start-while-busy and reset sequences.
// Filler-bit expectations switch on with TRAFFIC_PATTERN_GEN_NOISE_EN.
module tb_traffic_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] pattern;
  logic [7:0] repeat_cnt;
  logic [3:0] gap;
  logic       ready_in;
  logic       d_out;
  logic       valid_out;
  logic       busy;
  logic       done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  traffic_pattern_gen #(.PAT_W(5), .REP_W(8), .GAP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap        (gap),
    .ready_in   (ready_in),
    .d_out      (d_out),
    .valid_out  (valid_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Masks are right-aligned: bit (n-i) describes cycle N+i after the start edge N.
  typedef struct {
    string       name;
    logic [4:0]  pattern;
    logic [7:0]  rep;
    logic [3:0]  gap;
    int unsigned n;
    logic [31:0] rdy;
    logic [31:0] v;
    logic [31:0] d;
    int unsigned poke;
  } vec_t;

  vec_t tbl [9];

`ifdef TRAFFIC_PATTERN_GEN_NOISE_EN
  logic [7:0] lfsr_m;
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int unsigned cyc,
                     input logic ev, input logic ed, input logic edone, input logic ebusy);
    logic [3:0] act;
    logic [3:0] exp;
    act = {valid_out, valid_out ? d_out : 1'b0, done, busy};
    exp = {ev, ev ? ed : 1'b0, edone, ebusy};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: {valid,d,done,busy} actual %b required %b", name, cyc, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t);
    int unsigned b;
    logic        ev;
    logic        ed;
    pattern    = t.pattern;
    repeat_cnt = t.rep;
    gap        = t.gap;
    ready_in   = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int unsigned i = 1; i <= t.n; i++) begin
      b        = t.n - i;
      ready_in = t.rdy[b];
      if (t.poke == i) begin
        start      = 1'b1;
        pattern    = ~t.pattern;
        repeat_cnt = 8'd7;
        gap        = 4'd3;
      end
      ev = t.v[b];
      ed = t.d[b];
`ifdef TRAFFIC_PATTERN_GEN_NOISE_EN
      if (!t.v[b]) begin
        ev = 1'b1;
        ed = lfsr_m[0];
      end
`endif
      chk(t.name, i, ev, ed, 1'b0, 1'b1);
`ifdef TRAFFIC_PATTERN_GEN_NOISE_EN
      if (!t.v[b] && ready_in) lfsr_m = lfsr_step(lfsr_m);
`endif
      tick();
      start = 1'b0;
    end
    ready_in = 1'b1;
    chk({t.name, "_done"}, t.n + 1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk({t.name, "_idle"}, t.n + 2, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0] = '{"basic",      5'b01110, 8'd1, 4'd0,  5, '1, 32'b11111, 32'b01110, 0};
    tbl[1] = '{"rep3_gap2",  5'b01110, 8'd3, 4'd2, 19, '1,
               32'b1111100111110011111, 32'b0111000011100001110, 0};
    tbl[2] = '{"stall_idx2", 5'b01110, 8'd1, 4'd0,  8, 32'b11000111, 32'hFF, 32'b01111110, 0};
    tbl[3] = '{"start_busy", 5'b01110, 8'd1, 4'd0,  5, '1, 32'b11111, 32'b01110, 3};
    tbl[4] = '{"rep0",       5'b11001, 8'd0, 4'd3,  5, '1, 32'b11111, 32'b11001, 0};
    tbl[5] = '{"b2b",        5'b10110, 8'd2, 4'd0, 10, '1, 32'h3FF, 32'b1011010110, 0};
    tbl[6] = '{"gap1",       5'b10001, 8'd2, 4'd1, 11, '1, 32'b11111011111, 32'b10001010001, 0};
    tbl[7] = '{"rep2_gap4",  5'b01110, 8'd2, 4'd4, 14, '1,
               32'b11111000011111, 32'b01110000001110, 0};
    tbl[8] = '{"stall_wrap", 5'b10110, 8'd2, 4'd0, 12, 32'b111100111111, 32'hFFF,
               32'b101100010110, 0};

    // Reset held with start asserted: reset must win.
    rst        = 1'b1;
    start      = 1'b1;
    pattern    = 5'b11111;
    repeat_cnt = 8'd1;
    gap        = 4'd0;
    ready_in   = 1'b1;
`ifdef TRAFFIC_PATTERN_GEN_NOISE_EN
    lfsr_m = 8'hA5;
`endif
    tick();
    tick();
    chk("reset_state", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("post_reset_idle", 1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int unsigned k = 0; k < 9; k++) run_vec(tbl[k]);

    // Reset in cycle N+3 abandons the transfer with no done pulse.
    pattern    = 5'b01110;
    repeat_cnt = 8'd1;
    gap        = 4'd0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_mid_c1", 1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("rst_mid_c2", 2, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("rst_mid_c3", 3, 1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef TRAFFIC_PATTERN_GEN_NOISE_EN
    lfsr_m = 8'hA5;
`endif
    chk("rst_mid_c4", 4, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int unsigned c = 5; c < 8; c++) begin
      tick();
      chk("rst_mid_quiet", c, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    run_vec(tbl[0]);
    run_vec(tbl[7]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_pattern_gen.md
# traffic_pattern_gen

- Transmit-side counterpart of the vehicle-pattern detector.
- Serialises a programmable vehicle pattern (Bike = 0, Car = 1) onto a 1-bit stream with a valid/ready handshake.
- Can repeat the pattern with inter-pattern gaps.
- Drives the detector's `d_in`/`valid_in` during system test and in the traffic-stimulus path.

## Interface
- `PAT_W`, default 5: pattern length in bits; sent MSB first.
- `REP_W`, default 8: width of the repetition count.
- `GAP_W`, default 4: width of the gap count.
- `clk  input  1`: single clock; all logic on its rising edge.
- `rst  input  1`: synchronous, active-high reset.
- `start  input  1`: request to begin a transfer; sampled only in S_IDLE.
- `pattern  input  PAT_W`: pattern to send (default use 5'b01110 = BCCCB); latched on accepted start.
- `repeat_cnt  input  REP_W`: number of pattern repetitions; latched on start; 0 is treated as 1.
- `gap  input  GAP_W`: gap length between repetitions; latched on start; 0 = back-to-back.
- `ready_in  input  1`: downstream accepts the current bit.
- `d_out  output  1`: current vehicle bit; registered.
- `valid_out  output  1`: `d_out` is valid; registered.
- `busy  output  1`: high in every state except S_IDLE.
- `done  output  1`: one-cycle pulse when the final bit has been accepted.

## Operation
- **States:** S_IDLE, S_SEND, S_GAP, S_DONE.
- **Transfer:** a bit is transferred on any edge where `valid_out && ready_in`.
- **S_IDLE**
  - `start=1` latches `pattern`, `repeat_cnt` (0→1) and `gap`.
  - Clears the bit index and goes to S_SEND.
  - All outputs are 0.
- **S_SEND**
  - `valid_out=1`, `d_out = pattern_q[PAT_W-1-idx]`.
  - On transfer, `idx` increments.
  - On transfer of bit `PAT_W-1`:
    - `idx` resets to 0 and the repetition counter decrements.
    - Remaining repetitions = 0 → S_DONE.
    - Else `gap_q=0` → stay in S_SEND; next repetition's MSB is presented on the following cycle.
    - Else load the gap counter with `gap_q` → S_GAP.
- **S_GAP**
  - `valid_out=0`.
  - Gap counter decrements every cycle; at 1 → S_SEND.
  - Exactly `gap_q` idle cycles.
- **S_DONE**
  - `done=1`, `busy=1` and `valid_out=0` for one cycle → S_IDLE.
- **Handshake rule:** while `valid_out=1 && ready_in=0`, `d_out`, `valid_out` and the internal index hold. No bit is skipped or duplicated.
- **Boundary conditions:**
  - `start` while busy: ignored. Latched values are unaffected by input changes mid-transfer.
  - `rst` with `start` in the same cycle: reset wins.
  - `rst` mid-transfer: next cycle is S_IDLE with all outputs 0. The partial pattern is abandoned; `done` is not pulsed.
  - Illegal state encoding: recover to S_IDLE on the next edge.

## Timing
- **Reset values:** `d_out=0`, `valid_out=0`, `busy=0`, `done=0`; state S_IDLE; all counters 0.
- **Start latency:** `start` sampled at edge N → `valid_out=1` with the MSB during cycle N+1.
- **Total duration:** with `ready_in` constantly high, a transfer of R repetitions and gap G occupies `R*PAT_W + (R-1)*G` cycles, then 1 `done` cycle.
- **Next start:** `done` is high in the cycle after the final transfer. `busy` falls the cycle after `done`. A new `start` can be accepted in that S_IDLE cycle.

## Configuration
- **`TRAFFIC_PATTERN_GEN_NOISE_EN` defined:**
  - S_GAP emits filler traffic instead of idle cycles: `valid_out=1`, `d_out` = bit 0 of an 8-bit Fibonacci LFSR.
  - LFSR polynomial x^8+x^6+x^5+x^4+1, seeded to 8'hA5 on `rst`.
  - The LFSR advances only on a transfer.
  - The gap counter decrements only on transfers, so exactly `gap_q` filler bits are delivered.
  - The handshake rule applies to filler bits.
- **Macro not defined:** behaviour as in Operation (idle gaps); no LFSR logic is synthesised.

## Test plan
1. `pattern=5'b01110`, `repeat_cnt=1`, `gap=0`, `ready_in=1`, start at edge N.
   - `d_out`=0,1,1,1,0 with `valid_out=1` in cycles N+1..N+5.
   - `done=1` in N+6; `busy=0` from N+7.
2. `repeat_cnt=3`, `gap=2`, `ready_in=1`.
   - Bits in N+1..N+5, N+8..N+12, N+15..N+19.
   - `valid_out=0` in N+6,N+7 and N+13,N+14.
   - `done` in N+20.
3. Same as 1, with `ready_in=0` for 3 cycles while bit index 2 is presented.
   - `d_out=1` and `valid_out=1` held for 4 cycles.
   - The accepted sequence is exactly 0,1,1,1,0; `done` in N+9.
4. Start-handling checks:
   - Pulse `start` with a different pattern in cycle N+3 of scenario 1: ignored, output unchanged.
   - `repeat_cnt=0`: exactly one pattern is sent.
5. Reset checks:
   - Assert `rst` in cycle N+3: outputs all 0 the next cycle, no `done` pulse.
   - A new start afterwards sends the full pattern from the MSB.
6. With `TRAFFIC_PATTERN_GEN_NOISE_EN`, `repeat_cnt=2`, `gap=4`, `ready_in=1`:
   - 5 pattern bits, then 4 valid LFSR bits, first filler bit = 1 (seed A5), then 5 pattern bits.
   - `done` in N+15.
